// File: rtl/nic_ctrl.sv
// PE-side sequencer for the NIC register interface: polls status, fetches RX packets, pushes TX packets.
// Define NIC_CTRL_STATS_EN to add the rx_count/tx_count packet counters.
module nic_ctrl #(
    parameter int DW          = 64,
    parameter int STALL_LIMIT = 255
) (
    input  logic          clk,
    input  logic          reset,
    output logic          nic_en,
    output logic          nic_wr_en,
    output logic [1:0]    nic_addr,
    output logic [DW-1:0] nic_wdata,
    input  logic [DW-1:0] nic_rdata,
    output logic [DW-1:0] rx_data,
    output logic          rx_valid,
    input  logic          rx_ready,
    input  logic [DW-1:0] tx_data,
    input  logic          tx_valid,
    output logic          tx_ready,
    output logic          tx_stall
`ifdef NIC_CTRL_STATS_EN
    ,
    output logic [15:0]   rx_count,
    output logic [15:0]   tx_count
`endif
);

    localparam int CW = $clog2(STALL_LIMIT + 1);

    typedef enum logic [2:0] {
        IDLE, IN_STAT, IN_CHK, IN_READ, IN_CAP, OUT_STAT, OUT_CHK, OUT_WR
    } state_t;

    state_t          state_q, state_d;
    logic            last_served_q, last_served_d;
    logic            rx_full_q, tx_full_q, tx_stall_q;
    logic [DW-1:0]   rx_buf_q, tx_buf_q;
    logic [CW-1:0]   stall_cnt_q;
    logic            in_elig, out_elig;

    assign in_elig  = !rx_full_q;
    assign out_elig = tx_full_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            last_served_q <= 1'b1;
        end else begin
            state_q       <= state_d;
            last_served_q <= last_served_d;
        end
    end

    // Round robin in IDLE: last_served_q = 1 means the output side went last.
    always_comb begin
        state_d       = state_q;
        last_served_d = last_served_q;
        case (state_q)
            IDLE: begin
                if (in_elig && (!out_elig || last_served_q)) begin
                    state_d       = IN_STAT;
                    last_served_d = 1'b0;
                end else if (out_elig) begin
                    state_d       = OUT_STAT;
                    last_served_d = 1'b1;
                end
            end
            IN_STAT:  state_d = IN_CHK;
            IN_CHK:   state_d = nic_rdata[0] ? IN_READ : IDLE;
            IN_READ:  state_d = IN_CAP;
            IN_CAP:   state_d = IDLE;
            OUT_STAT: state_d = OUT_CHK;
            OUT_CHK:  state_d = nic_rdata[0] ? IDLE : OUT_WR;
            OUT_WR:   state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        nic_en    = 1'b0;
        nic_wr_en = 1'b0;
        nic_addr  = 2'b00;
        nic_wdata = '0;
        case (state_q)
            IN_STAT: begin
                nic_en   = 1'b1;
                nic_addr = 2'b01;
            end
            IN_READ: begin
                nic_en   = 1'b1;
                nic_addr = 2'b00;
            end
            OUT_STAT: begin
                nic_en   = 1'b1;
                nic_addr = 2'b11;
            end
            OUT_WR: begin
                nic_en    = 1'b1;
                nic_wr_en = 1'b1;
                nic_addr  = 2'b10;
                nic_wdata = tx_buf_q;
            end
            default: ;
        endcase
    end

    // Holding registers; the FSM guarantees capture/drain never collide with the PE handshakes.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_full_q   <= 1'b0;
            rx_buf_q    <= '0;
            tx_full_q   <= 1'b0;
            tx_buf_q    <= '0;
            stall_cnt_q <= '0;
            tx_stall_q  <= 1'b0;
        end else begin
            if (state_q == IN_CAP) begin
                rx_buf_q  <= nic_rdata;
                rx_full_q <= 1'b1;
            end else if (rx_full_q && rx_ready) begin
                rx_full_q <= 1'b0;
            end

            if (state_q == OUT_WR) begin
                tx_full_q   <= 1'b0;
                stall_cnt_q <= '0;
                tx_stall_q  <= 1'b0;
            end else begin
                if (tx_valid && !tx_full_q) begin
                    tx_buf_q  <= tx_data;
                    tx_full_q <= 1'b1;
                end
                if (state_q == OUT_CHK && nic_rdata[0]) begin
                    if (stall_cnt_q != CW'(STALL_LIMIT))
                        stall_cnt_q <= stall_cnt_q + CW'(1);
                    if (stall_cnt_q >= CW'(STALL_LIMIT - 1))
                        tx_stall_q <= 1'b1;
                end
            end
        end
    end

    assign rx_valid = rx_full_q;
    assign rx_data  = rx_buf_q;
    assign tx_ready = !tx_full_q;
    assign tx_stall = tx_stall_q;

`ifdef NIC_CTRL_STATS_EN
    logic [15:0] rx_count_q, tx_count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_count_q <= '0;
            tx_count_q <= '0;
        end else begin
            if (state_q == IN_CAP) rx_count_q <= rx_count_q + 16'd1;
            if (state_q == OUT_WR) tx_count_q <= tx_count_q + 16'd1;
        end
    end

    assign rx_count = rx_count_q;
    assign tx_count = tx_count_q;
`endif

endmodule

// File: tb/tb_nic_ctrl.sv
// Self-checking bench for nic_ctrl: behavioural NIC model, directed scenarios and a randomized scoreboard run.
module tb_nic_ctrl;
    localparam int DW  = 64;
    localparam int LIM = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          nic_en, nic_wr_en;
    logic [1:0]    nic_addr;
    logic [DW-1:0] nic_wdata, nic_rdata;
    logic [DW-1:0] rx_data;
    logic          rx_valid, rx_ready;
    logic [DW-1:0] tx_data;
    logic          tx_valid, tx_ready, tx_stall;
`ifdef NIC_CTRL_STATS_EN
    logic [15:0]   rx_count, tx_count;
`endif

    int checks = 0;
    int errors = 0;
    int protoErr = 0;

    logic [DW-1:0] inQ[$];
    logic          outBusy;

    always #5 clk = ~clk;

    nic_ctrl #(.DW(DW), .STALL_LIMIT(LIM)) dut (
        .clk(clk), .reset(reset),
        .nic_en(nic_en), .nic_wr_en(nic_wr_en), .nic_addr(nic_addr),
        .nic_wdata(nic_wdata), .nic_rdata(nic_rdata),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .tx_stall(tx_stall)
`ifdef NIC_CTRL_STATS_EN
        , .rx_count(rx_count), .tx_count(tx_count)
`endif
    );

    // NIC model: registered read data, one input FIFO, one-entry output buffer.
    always @(posedge clk) begin
        if (reset) begin
            nic_rdata <= '0;
        end else if (nic_en && !nic_wr_en) begin
            case (nic_addr)
                2'b01: nic_rdata <= {{(DW-1){1'b0}}, (inQ.size() != 0)};
                2'b11: nic_rdata <= {{(DW-1){1'b0}}, outBusy};
                2'b00: begin
                    if (inQ.size() == 0) begin
                        protoErr++;
                        nic_rdata <= '0;
                    end else begin
                        nic_rdata <= inQ.pop_front();
                    end
                end
                default: protoErr++;
            endcase
        end else if (nic_en && nic_wr_en) begin
            if (nic_addr != 2'b10 || outBusy) protoErr++;
            outBusy = 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        reset    = 1'b1;
        rx_ready = 1'b0;
        tx_valid = 1'b0;
        tx_data  = '0;
        inQ.delete();
        outBusy  = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        rx_ready = 1'b0;
        tx_valid = 1'b0;
        tx_data  = '0;
        outBusy  = 1'b0;
        inQ.delete();
        tick();
        tick();
        checks++;
        if ({nic_en, nic_wr_en, nic_addr, rx_valid, tx_stall, tx_ready} !== 7'b0000001) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: got %b want 0000001",
                     {nic_en, nic_wr_en, nic_addr, rx_valid, tx_stall, tx_ready});
        end
        checks++;
        if (rx_data !== '0 || nic_wdata !== '0) begin
            errors++;
            $display("[TB] FAIL reset_data: rx_data %h nic_wdata %h want 0", rx_data, nic_wdata);
        end
`ifdef NIC_CTRL_STATS_EN
        checks++;
        if (rx_count !== 16'd0 || tx_count !== 16'd0) begin
            errors++;
            $display("[TB] FAIL reset_stats: rx %0d tx %0d want 0", rx_count, tx_count);
        end
`endif
        reset = 1'b0;
        tick();
        checks++;
        if ({nic_en, nic_wr_en, nic_addr} !== 4'b1001) begin
            errors++;
            $display("[TB] FAIL first_access: got %b want 1001", {nic_en, nic_wr_en, nic_addr});
        end
    endtask

    task automatic test_rx();
        logic [DW-1:0] pkt;
        logic          p1En, p2En;
        logic [1:0]    p1Addr, p2Addr;
        bit            found;
        int            pollCount;
        pkt    = 64'hDEAD_BEEF_0000_0001;
        inQ.push_back(pkt);
        p1En   = nic_en;
        p1Addr = nic_addr;
        p2En   = 1'b0;
        p2Addr = 2'b00;
        found  = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (nic_en && !nic_wr_en && nic_addr == 2'b00) begin
                found = 1'b1;
                break;
            end
            p2En = p1En; p2Addr = p1Addr;
            p1En = nic_en; p1Addr = nic_addr;
        end
        checks++;
        if (!found || p1En !== 1'b0 || p2En !== 1'b1 || p2Addr !== 2'b01) begin
            errors++;
            $display("[TB] FAIL rx_sequence: found %0d prev %b/%b prev2 %b/%b want 1 0 then 1/01",
                     found, p1En, p1Addr, p2En, p2Addr);
        end
        tick();
        checks++;
        if (rx_valid !== 1'b0 || nic_en !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rx_cap_cycle: rx_valid %b nic_en %b want 0 0", rx_valid, nic_en);
        end
        tick();
        checks++;
        if (rx_valid !== 1'b1 || rx_data !== pkt) begin
            errors++;
            $display("[TB] FAIL rx_latency: rx_valid %b rx_data %h want 1 %h", rx_valid, rx_data, pkt);
        end
        pollCount = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (nic_en) pollCount++;
        end
        checks++;
        if (pollCount != 0 || rx_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL rx_hold_no_poll: accesses %0d rx_valid %b want 0 1", pollCount, rx_valid);
        end
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        checks++;
        if (rx_valid !== 1'b0 || nic_en !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rx_handshake: rx_valid %b nic_en %b want 0 0", rx_valid, nic_en);
        end
        tick();
        checks++;
        if ({nic_en, nic_wr_en, nic_addr} !== 4'b1001) begin
            errors++;
            $display("[TB] FAIL rx_repoll: got %b want 1001", {nic_en, nic_wr_en, nic_addr});
        end
    endtask

    task automatic test_tx();
        logic [DW-1:0] pkt;
        bit            found, saw11;
        int            n;
        pkt = 64'h8000_0000_0000_00A5;
        checks++;
        if (tx_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL tx_ready_idle: got %b want 1", tx_ready);
        end
        tx_data  = pkt;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        checks++;
        if (tx_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL tx_accept: tx_ready %b want 0", tx_ready);
        end
        found = 1'b0;
        saw11 = 1'b0;
        n     = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            n++;
            if (nic_en && !nic_wr_en && nic_addr == 2'b11) saw11 = 1'b1;
            if (nic_en && nic_wr_en) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (!found || !saw11 || nic_addr !== 2'b10 || nic_wdata !== pkt || n < 3) begin
            errors++;
            $display("[TB] FAIL tx_write: found %0d status %0d addr %b data %h after %0d want 1 1 10 %h >=3",
                     found, saw11, nic_addr, nic_wdata, n, pkt);
        end
        tick();
        checks++;
        if (tx_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL tx_ready_return: got %b want 1", tx_ready);
        end
`ifdef NIC_CTRL_STATS_EN
        checks++;
        if (tx_count !== 16'd1 || rx_count !== 16'd1) begin
            errors++;
            $display("[TB] FAIL stats_count: rx %0d tx %0d want 1 1", rx_count, tx_count);
        end
`endif
    endtask

    task automatic test_stall();
        logic [DW-1:0] pkt;
        bit            found;
        doReset();
        outBusy  = 1'b1;
        pkt      = {$urandom, $urandom};
        tx_data  = pkt;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        for (int k = 1; k <= LIM + 1; k++) begin
            found = 1'b0;
            for (int i = 0; i < 20; i++) begin
                tick();
                if (nic_en && !nic_wr_en && nic_addr == 2'b11) begin
                    found = 1'b1;
                    break;
                end
            end
            tick();
            tick();
            checks++;
            if (!found || tx_stall !== (k >= LIM) || tx_ready !== 1'b0) begin
                errors++;
                $display("[TB] FAIL stall_poll%0d: found %0d tx_stall %b tx_ready %b want 1 %b 0",
                         k, found, tx_stall, tx_ready, (k >= LIM));
            end
        end
        outBusy = 1'b0;
        found   = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (nic_en && nic_wr_en) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (!found || nic_wdata !== pkt) begin
            errors++;
            $display("[TB] FAIL stall_release_write: found %0d data %h want 1 %h", found, nic_wdata, pkt);
        end
        tick();
        checks++;
        if (tx_stall !== 1'b0 || tx_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL stall_clear: tx_stall %b tx_ready %b want 0 1", tx_stall, tx_ready);
        end
    endtask

    // Randomized traffic: scoreboard for both directions plus a round-robin arbitration model.
    task automatic test_round_robin();
        logic [DW-1:0] rxExp[$];
        logic [DW-1:0] txExp[$];
        logic [DW-1:0] pkt;
        logic          prevRxValid, prevTxReady;
        bit            lastSide, side, inE, outE, expSide, stop;
        int            rrErr, rrCount;
        doReset();
        lastSide    = 1'b1;
        prevRxValid = rx_valid;
        prevTxReady = tx_ready;
        rrErr       = 0;
        rrCount     = 0;
        for (int i = 0; i < 900; i++) begin
            stop = (i >= 600);
            if (stop && rxExp.size() == 0 && txExp.size() == 0) break;
            tick();
            if (nic_en && !nic_wr_en && (nic_addr == 2'b01 || nic_addr == 2'b11)) begin
                side    = (nic_addr == 2'b11);
                inE     = !prevRxValid;
                outE    = !prevTxReady;
                expSide = (inE && outE) ? !lastSide : outE;
                rrCount++;
                checks++;
                if (!(inE || outE) || side !== expSide) begin
                    errors++;
                    rrErr++;
                    if (rrErr < 5)
                        $display("[TB] FAIL rr_arbitration: served %0d want %0d (in %0d out %0d)",
                                 side, expSide, inE, outE);
                end
                lastSide = side;
            end
            if (nic_en && nic_wr_en) begin
                checks++;
                if (txExp.size() == 0 || nic_wdata !== txExp[0]) begin
                    errors++;
                    $display("[TB] FAIL tx_scoreboard: got %h want %h", nic_wdata,
                             (txExp.size() != 0) ? txExp[0] : '0);
                end
                if (txExp.size() != 0) void'(txExp.pop_front());
            end
            prevRxValid = rx_valid;
            prevTxReady = tx_ready;
            if (outBusy && $urandom_range(3) == 0) outBusy = 1'b0;
            rx_ready = stop ? 1'b1 : 1'($urandom_range(1));
            if (rx_valid && rx_ready) begin
                checks++;
                if (rxExp.size() == 0 || rx_data !== rxExp[0]) begin
                    errors++;
                    $display("[TB] FAIL rx_scoreboard: got %h want %h", rx_data,
                             (rxExp.size() != 0) ? rxExp[0] : '0);
                end
                if (rxExp.size() != 0) void'(rxExp.pop_front());
            end
            tx_valid = !stop && ($urandom_range(2) != 0);
            tx_data  = {$urandom, $urandom};
            if (tx_valid && tx_ready) txExp.push_back(tx_data);
            if (!stop && inQ.size() < 2 && $urandom_range(1) == 1) begin
                pkt = {$urandom, $urandom};
                inQ.push_back(pkt);
                rxExp.push_back(pkt);
            end
        end
        tx_valid = 1'b0;
        rx_ready = 1'b0;
        checks++;
        if (rxExp.size() != 0 || txExp.size() != 0 || rrCount < 20) begin
            errors++;
            $display("[TB] FAIL random_drain: rx left %0d tx left %0d arbitrations %0d want 0 0 >=20",
                     rxExp.size(), txExp.size(), rrCount);
        end
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] pkt;
        bit            found;
        doReset();
        pkt = {$urandom, $urandom};
        inQ.push_back(pkt);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (nic_en && !nic_wr_en && nic_addr == 2'b00) begin
                found = 1'b1;
                break;
            end
        end
        reset = 1'b1;
        tick();
        checks++;
        if (!found || nic_en !== 1'b0 || rx_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_mid: found %0d nic_en %b rx_valid %b want 1 0 0", found, nic_en, rx_valid);
        end
`ifdef NIC_CTRL_STATS_EN
        checks++;
        if (rx_count !== 16'd0) begin
            errors++;
            $display("[TB] FAIL reset_mid_stats: rx_count %0d want 0", rx_count);
        end
`endif
        reset = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (rx_valid) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (!found || rx_data !== pkt) begin
            errors++;
            $display("[TB] FAIL reset_mid_refetch: found %0d rx_data %h want 1 %h", found, rx_data, pkt);
        end
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_rx();
        test_tx();
        test_stall();
        test_round_robin();
        test_reset_mid();
        checks++;
        if (protoErr != 0) begin
            errors++;
            $display("[TB] FAIL nic_protocol: violations %0d want 0", protoErr);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
